// File: rtl/exec_mdu_ctrl_if.sv
// Request/response bundle between the execute stage and the RV32M multiply/divide sequencer.
// master = core side (drives request and flush), slave = exec_mdu_ctrl.
interface exec_mdu_ctrl_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            stall;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_result;

    modport master (
        output req_valid, funct3, op_a, op_b, flush,
        input  req_ready, stall, rsp_valid, rsp_result
    );

    modport slave (
        input  req_valid, funct3, op_a, op_b, flush,
        output req_ready, stall, rsp_valid, rsp_result
    );
endinterface

// File: rtl/exec_mdu_ctrl.sv
// Iterative RV32M sequencer: 32-step shift-add multiplier and restoring divider, 34-cycle fixed latency.
// Define MDU_DIV_EN to build the divider; without it divide/remainder ops complete with a zero result.
module exec_mdu_ctrl #(
    parameter int XLEN = 32
) (
    input  logic           clk,
    input  logic           rst,
    exec_mdu_ctrl_if.slave bus
);
    localparam int PW = 2 * XLEN;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]      state;
    logic [4:0]      cnt;
    logic [2:0]      op_q;
    logic            sgn_diff;
    logic [XLEN-1:0] opnd;
    logic [PW-1:0]   acc;
    logic [XLEN-1:0] res_q;

    function automatic logic [XLEN-1:0] cond_neg_x(input logic [XLEN-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [PW-1:0] cond_neg_p(input logic [PW-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    logic            sgn_a, sgn_b, a_neg, b_neg;
    logic [XLEN-1:0] abs_a, abs_b;

    always_comb begin
        sgn_a = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
        sgn_b = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
        a_neg = sgn_a & bus.op_a[XLEN-1];
        b_neg = sgn_b & bus.op_b[XLEN-1];
        abs_a = cond_neg_x(bus.op_a, a_neg);
        abs_b = cond_neg_x(bus.op_b, b_neg);
    end

`ifdef MDU_DIV_EN
    logic            neg_rem, div_zero, div_ovf;
    logic [XLEN:0]   div_sub;
    logic [XLEN-1:0] quot, rem;
`endif

    // One iteration: multiply adds the multiplicand into the high half and shifts right;
    // divide shifts remainder:quotient left and keeps the trial subtraction if it did not borrow.
    logic [XLEN:0]   mul_sum;
    logic [PW-1:0]   mul_next, step_next;

    always_comb begin
        mul_sum   = {1'b0, acc[PW-1:XLEN]} + {1'b0, {XLEN{acc[0]}} & opnd};
        mul_next  = {mul_sum, acc[XLEN-1:1]};
        step_next = op_q[2] ? acc : mul_next;
`ifdef MDU_DIV_EN
        div_sub = acc[PW-1:XLEN-1] - {1'b0, opnd};
        if (op_q[2]) begin
            step_next = div_sub[XLEN] ? {acc[PW-2:0], 1'b0}
                                      : {div_sub[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end
`endif
    end

    logic [PW-1:0]   prod;
    logic [XLEN-1:0] fix_res;

    always_comb begin
        prod    = cond_neg_p(acc, sgn_diff);
        fix_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[PW-1:XLEN];
        if (op_q[2]) fix_res = '0;
`ifdef MDU_DIV_EN
        quot = cond_neg_x(acc[XLEN-1:0], sgn_diff);
        rem  = cond_neg_x(acc[PW-1:XLEN], neg_rem);
        // Divide-by-zero leaves |op_a| as remainder, which re-signs back to op_a.
        if (div_zero) quot = '1;
        if (div_ovf) begin
            quot = {1'b1, {(XLEN-1){1'b0}}};
            rem  = '0;
        end
        if (op_q[2]) fix_res = op_q[1] ? rem : quot;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            op_q     <= '0;
            sgn_diff <= 1'b0;
            opnd     <= '0;
            acc      <= '0;
            res_q    <= '0;
`ifdef MDU_DIV_EN
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
`endif
        end else if (bus.flush) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        state    <= S_RUN;
                        cnt      <= '0;
                        op_q     <= bus.funct3;
                        sgn_diff <= a_neg ^ b_neg;
                        opnd     <= bus.funct3[2] ? abs_b : abs_a;
                        acc      <= {{XLEN{1'b0}}, (bus.funct3[2] ? abs_a : abs_b)};
`ifdef MDU_DIV_EN
                        neg_rem  <= a_neg;
                        div_zero <= (bus.op_b == '0);
                        div_ovf  <= sgn_b && (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) &&
                                    (bus.op_b == '1);
`endif
                    end
                end
                S_RUN: begin
                    acc <= step_next;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= S_FIX;
                end
                S_FIX: begin
                    res_q <= fix_res;
                    state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state == S_IDLE);
    assign bus.rsp_valid  = (state == S_DONE) && !bus.flush;
    assign bus.stall      = bus.req_valid & ~bus.rsp_valid;
    assign bus.rsp_result = res_q;
endmodule

// File: tb/tb_exec_mdu_ctrl.sv
// Directed bench for exec_mdu_ctrl; expected divide results follow MDU_DIV_EN.
module tb_exec_mdu_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [31:0] last_res = 32'h0;

`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    exec_mdu_ctrl_if #(.XLEN(32)) bus ();
    exec_mdu_ctrl #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] dexp(input logic [31:0] v);
        return DIV_EN ? v : 32'h0;
    endfunction

    // Starts at a negedge (cycle T), accepts at the end of T, returns at the negedge of T+35.
    // lat = cycle offset of rsp_valid (-1 on timeout); hs_ok = stall/req_ready correct throughout.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input bit hold, output int lat, output logic [31:0] res,
                          output bit hs_ok);
        bus.req_valid = 1'b1;
        bus.funct3    = f3;
        bus.op_a      = a;
        bus.op_b      = b;
        #1;
        hs_ok = (bus.stall === 1'b1) && (bus.req_ready === 1'b1);
        lat   = -1;
        res   = 32'hxxxx_xxxx;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.op_a   = ~a;
                bus.op_b   = ~b;
                bus.funct3 = f3 ^ 3'b111;
            end
            if (bus.rsp_valid === 1'b1) begin
                lat = k;
                res = bus.rsp_result;
                if (bus.stall !== 1'b0 || bus.req_ready !== 1'b0) hs_ok = 1'b0;
            end else if (bus.stall !== 1'b1 || bus.req_ready !== 1'b0) begin
                hs_ok = 1'b0;
            end
        end
        if (!hold) bus.req_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (bus.req_ready !== 1'b1) $display("FAIL reset req_ready: got %b expected 1", bus.req_ready); else n_pass++;
        n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset rsp_valid: got %b expected 0", bus.rsp_valid); else n_pass++;
        n_checks++; if (bus.rsp_result !== 32'h0) $display("FAIL reset rsp_result: got %h expected 0", bus.rsp_result); else n_pass++;
        n_checks++; if (bus.stall !== 1'b0) $display("FAIL reset stall_low: got %b expected 0", bus.stall); else n_pass++;
        bus.req_valid = 1'b1;
        #1;
        n_checks++; if (bus.stall !== 1'b1) $display("FAIL reset stall_high: got %b expected 1", bus.stall); else n_pass++;
        bus.req_valid = 1'b0;
    endtask

    task automatic test_mul();
        logic [2:0]  f3s [5] = '{3'b001, 3'b011, 3'b000, 3'b010, 3'b001};
        logic [31:0] as  [5] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bs  [5] = '{32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exs [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
        int lat; logic [31:0] res; bit hs;
        for (int i = 0; i < 5; i++) begin
            run_op(f3s[i], as[i], bs[i], 1'b0, lat, res, hs);
            n_checks++; if (lat !== 34) $display("FAIL mul[%0d] latency: got %0d expected 34", i, lat); else n_pass++;
            n_checks++; if (res !== exs[i]) $display("FAIL mul[%0d] result: got %h expected %h", i, res, exs[i]); else n_pass++;
            n_checks++; if (!hs) $display("FAIL mul[%0d] stall_ready: got 0 expected 1", i); else n_pass++;
        end
    endtask

    task automatic test_div();
        logic [2:0]  f3s [10] = '{3'b100, 3'b110, 3'b100, 3'b110, 3'b100,
                                  3'b110, 3'b101, 3'b111, 3'b111, 3'b101};
        logic [31:0] as  [10] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9,
                                  32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5};
        logic [31:0] bs  [10] = '{32'd2, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,
                                  32'd0, 32'd7, 32'd7, 32'd0, 32'd0};
        logic [31:0] exs [10] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF,
                                  32'hFFFF_FFF9, 32'd14, 32'd2, 32'd5, 32'hFFFF_FFFF};
        int lat; logic [31:0] res; bit hs;
        for (int i = 0; i < 10; i++) begin
            run_op(f3s[i], as[i], bs[i], 1'b0, lat, res, hs);
            n_checks++; if (lat !== 34) $display("FAIL div[%0d] latency: got %0d expected 34", i, lat); else n_pass++;
            n_checks++; if (res !== dexp(exs[i])) $display("FAIL div[%0d] result: got %h expected %h", i, res, dexp(exs[i])); else n_pass++;
            n_checks++; if (!hs) $display("FAIL div[%0d] stall_ready: got 0 expected 1", i); else n_pass++;
            last_res = dexp(exs[i]);
        end
    endtask

    task automatic test_flush();
        int lat; logic [31:0] res; bit hs; bit seen;
        bus.req_valid = 1'b1;
        bus.funct3    = 3'b101;
        bus.op_a      = 32'd100;
        bus.op_b      = 32'd7;
        seen = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) seen = 1'b1;
        end
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        if (bus.rsp_valid === 1'b1) seen = 1'b1;
        n_checks++; if (bus.req_ready !== 1'b1) $display("FAIL flush idle: got req_ready %b expected 1", bus.req_ready); else n_pass++;
        n_checks++; if (seen) $display("FAIL flush no_rsp: got rsp_valid 1 expected 0"); else n_pass++;
        n_checks++; if (bus.rsp_result !== last_res) $display("FAIL flush result_hold: got %h expected %h", bus.rsp_result, last_res); else n_pass++;
        run_op(3'b101, 32'd100, 32'd7, 1'b0, lat, res, hs);
        n_checks++; if (lat !== 34) $display("FAIL flush retry latency: got %0d expected 34", lat); else n_pass++;
        n_checks++; if (res !== dexp(32'd14)) $display("FAIL flush retry result: got %h expected %h", res, dexp(32'd14)); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] res; bit hs;
        run_op(3'b000, 32'd3, 32'd4, 1'b1, lat, res, hs);
        n_checks++; if (lat !== 34) $display("FAIL b2b first latency: got %0d expected 34", lat); else n_pass++;
        n_checks++; if (res !== 32'd12) $display("FAIL b2b first result: got %h expected %h", res, 32'd12); else n_pass++;
        n_checks++; if (!hs) $display("FAIL b2b first stall_ready: got 0 expected 1"); else n_pass++;
        run_op(3'b000, 32'd5, 32'd6, 1'b0, lat, res, hs);
        n_checks++; if (lat !== 34) $display("FAIL b2b second latency: got %0d expected 34", lat); else n_pass++;
        n_checks++; if (res !== 32'd30) $display("FAIL b2b second result: got %h expected %h", res, 32'd30); else n_pass++;
        n_checks++; if (!hs) $display("FAIL b2b second stall_ready: got 0 expected 1"); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        bus.req_valid = 1'b1;
        bus.funct3    = 3'b000;
        bus.op_a      = 32'd7;
        bus.op_b      = 32'd9;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL midrst rsp_valid: got %b expected 0", bus.rsp_valid); else n_pass++;
        n_checks++; if (bus.rsp_result !== 32'h0) $display("FAIL midrst rsp_result: got %h expected 0", bus.rsp_result); else n_pass++;
        n_checks++; if (bus.req_ready !== 1'b1) $display("FAIL midrst req_ready: got %b expected 1", bus.req_ready); else n_pass++;
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst  = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) seen = 1'b1;
        end
        n_checks++; if (seen) $display("FAIL midrst no_rsp: got rsp_valid 1 expected 0"); else n_pass++;
    endtask

    initial begin
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        bus.funct3    = 3'b000;
        bus.op_a      = 32'h0;
        bus.op_b      = 32'h0;
        bus.flush     = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        test_mul();
        test_div();
        test_flush();
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/exec_mdu_ctrl.md
# exec_mdu_ctrl

Iterative multiply/divide sequencer for the RV32M instructions of the execute stage. It accepts one operation from decode/execute, runs a fixed-latency shift-add multiplier or restoring divider over 32 iterations, and stalls the core's PC update until the result is ready. The block sits beside the single-cycle ALU: the ALU handles RV32I, and this block supplies `rsp_result` to the write-back mux for `opcode == 0110011 && funct7 == 0000001`.

## Interface
Parameters:
- `XLEN`, 32, operand/result width; only 32 is supported.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  the current instruction is an M-extension op.
- `req_ready`  out  1  high only in IDLE.
- `funct3`  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a`  in  32  rs1 value.
- `op_b`  in  32  rs2 value.
- `flush`  in  1  abort the operation in flight.
- `stall`  out  1  hold PC/regfile write while high.
- `rsp_valid`  out  1  one-cycle pulse; `rsp_result` is valid.
- `rsp_result`  out  32  final result; holds its last value until the next response.

## Operation
- FSM states: IDLE, RUN, FIX, DONE.
- **IDLE**
  - On `req_valid` (accept): latch `funct3`, `|op_a|`, `|op_b|` and the sign flags; clear the accumulator; set `cnt` = 0; go to RUN.
  - Signed treatment per op: MULH/DIV/REM are signed×signed; MULHSU has `op_a` signed and `op_b` unsigned; the remaining ops are unsigned.
- **RUN**
  - One iteration per cycle: multiply does add-and-shift on a 64-bit product; divide does shift-subtract-restore on a 64-bit remainder:quotient.
  - `cnt` increments 0..31; at `cnt == 31` go to FIX.
- **FIX** applies sign correction:
  - Product negated if the operand signs differ (signed ops only).
  - Quotient negated if the signs differ; remainder takes the dividend's sign.
  - Result select: MUL = product[31:0]; MULH/MULHSU/MULHU = product[63:32]; DIV/DIVU = quotient; REM/REMU = remainder.
  - Then go to DONE.
- **DONE**: `rsp_valid` = 1, `rsp_result` registered; go to IDLE next cycle.
- `stall` = `req_valid & ~rsp_valid` (combinational). The core advances exactly in the DONE cycle.
- Divide by zero, fixed latency:
  - DIV/DIVU → 32'hFFFF_FFFF.
  - REM/REMU → `op_a`.
- Signed overflow (`op_a` = 32'h8000_0000, `op_b` = 32'hFFFF_FFFF):
  - DIV → 32'h8000_0000.
  - REM → 0.
- The special cases are detected at accept, and the override is applied in FIX.
- `flush` in any state: next state IDLE, no `rsp_valid`, `rsp_result` unchanged. `flush` has priority over accept in IDLE.
- `op_a`, `op_b`, `funct3` are sampled only at accept; later changes are ignored.

## Timing
- Reset (`rst` = 0, asynchronous): state IDLE, `cnt` = 0, `rsp_valid` = 0, `rsp_result` = 0, internal accumulators 0.
  - `req_ready` = 1.
  - `stall` follows `req_valid`.
- Reset mid-operation aborts without a response.
- Accept at edge T; RUN occupies cycles T+1..T+32; FIX is T+33; DONE (`rsp_valid` = 1) is T+34.
- Latency is 34 cycles for every op, including the special cases.
- Back-to-back: the next accept can occur in the IDLE cycle directly after DONE. Minimum spacing between `rsp_valid` pulses is 35 cycles.
- `req_ready` is low in RUN/FIX/DONE. `req_valid` held during those states is not a new request.

## Configuration
- `MDU_DIV_EN` defined:
  - The full divider datapath is present.
  - All eight ops are supported as above.
- `MDU_DIV_EN` undefined:
  - Divider logic is removed; only the 64-bit product path remains.
  - Ops with `funct3[2]` = 1 are still accepted and follow the identical 34-cycle sequence, returning `rsp_result` = 32'h0000_0000.
  - MUL* behaviour and timing are unchanged.

## Test plan
- Reset mid-RUN: accept MUL, assert `rst` = 0 at cycle T+10 → `rsp_valid` = 0, `rsp_result` = 0, `req_ready` = 1 immediately after reset.
- MULH with `op_a` = 32'hFFFF_FFFE (−2), `op_b` = 32'h0000_0003 → `rsp_result` = 32'hFFFF_FFFF at T+34; `stall` high T..T+33, low at T+34.
- MULHU with 32'hFFFF_FFFF × 32'hFFFF_FFFF → `rsp_result` = 32'hFFFF_FFFE; MUL with the same operands → 32'h0000_0001.
- Divide corners:
  - DIV −7/2 → 32'hFFFF_FFFD; REM −7/2 → 32'hFFFF_FFFF.
  - DIVU 5/0 → 32'hFFFF_FFFF; REMU 5/0 → 5.
  - DIV 32'h8000_0000/−1 → 32'h8000_0000; REM of the same → 0.
  - All four at T+34. Without `MDU_DIV_EN`, every one returns 0.
- `flush` at T+20 during DIVU 100/7 → no `rsp_valid`, IDLE at T+21. A new DIVU 100/7 accepted at T+21 → `rsp_result` = 14 at T+55.
- Back-to-back MUL 3×4 then MUL 5×6 with `req_valid` held → responses 12 at T+34 and 30 at T+69. `req_ready` = 0 between accepts.
